// File: rtl/seq_shift_mult.sv
// Sequential shift-add Q1.FRAC magnitude multiplier with saturation; sign passes through untouched.
// Optional SEQ_SHIFT_MULT_ROUND_EN selects round-half-up instead of truncation on the final shift.
module seq_shift_mult #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             sign
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = 2 * WIDTH;
    localparam int QW = AW + 1 - FRAC;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b;
    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_lat;
    logic [WIDTH-1:0] r_product;
    logic             r_sign;
    logic             r_done;

    logic [AW-1:0]    w_add;
    logic [AW:0]      w_sum;
    logic [QW-1:0]    w_q;
    logic [QW-1:0]    w_qmax;
    logic [WIDTH-1:0] w_prod;
    logic             w_last;

    assign w_add  = r_b[0] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
    assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef SEQ_SHIFT_MULT_ROUND_EN
    assign w_sum = {1'b0, r_acc} + ((AW + 1)'(1) << (FRAC - 1));
`else
    assign w_sum = {1'b0, r_acc};
`endif

    assign w_q    = QW'(w_sum >> FRAC);
    // Clamp to the largest positive value so the downstream negation never overflows.
    assign w_qmax = {{(QW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    assign w_prod = (w_q > w_qmax) ? {1'b0, {(WIDTH - 1){1'b1}}} : w_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (w_last) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sign_lat <= 1'b0;
            r_product  <= '0;
            r_sign     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_a        <= a;
                    r_b        <= b;
                    r_sign_lat <= sign_in;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                end
                // Always runs the full WIDTH iterations, even once r_b has emptied.
                S_CALC: begin
                    r_acc <= r_acc + w_add;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIN: begin
                    r_product <= w_prod;
                    r_sign    <= r_sign_lat;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign product = r_product;
    assign sign    = r_sign;

endmodule

// File: tb/tb_seq_shift_mult.sv
// Bench for seq_shift_mult: vector table plus handshake corner sequences, checked through a scoreboard.
`timescale 1ns/1ps
module tb_seq_shift_mult;
    localparam int WIDTH = 16;
    localparam int FRAC  = 15;
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             sign_in = 1'b0;
    logic             busy, done, sign;
    logic [WIDTH-1:0] product;

    seq_shift_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sign_in(sign_in),
        .busy(busy), .done(done), .product(product), .sign(sign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] exp_t;
        logic [15:0] exp_r;
    } vec_t;

    typedef struct {
        logic [15:0] prod;
        logic        s;
        int          start_cyc;
    } sb_t;

    sb_t sb[$];
    int  checks = 0, errors = 0;
    int  cyc = 0, n_done = 0, busy_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (!rst && done) begin
            sb_t e;
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("product", int'(product), int'(e.prod));
                chk("sign", int'(sign), int'(e.s));
                chk("latency", cyc - e.start_cyc, LAT);
            end
        end
    end

    task automatic push_exp(input logic [15:0] et, input logic [15:0] er, input logic s);
        sb_t e;
`ifdef SEQ_SHIFT_MULT_ROUND_EN
        e.prod = er;
`else
        e.prod = et;
`endif
        e.s = s;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
    endtask

    // Drives one start pulse at a falling edge; operands are scrambled after the accepting edge.
    task automatic do_op(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                         input logic [15:0] et, input logic [15:0] er);
        @(negedge clk);
        a = va; b = vb; sign_in = vs; start = 1'b1;
        push_exp(et, er, vs);
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sign_in = 1'($urandom);
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_product"}, int'(product), 0);
        chk({tag, "_sign"}, int'(sign), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    vec_t vecs[9];
    int   d0;

    initial begin
        vecs[0] = '{16'h4000, 16'h4000, 1'b1, 16'h2000, 16'h2000};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h7FFF, 16'h7FFF};
        vecs[2] = '{16'h0000, 16'h1234, 1'b1, 16'h0000, 16'h0000};
        vecs[3] = '{16'h0001, 16'h4000, 1'b0, 16'h0000, 16'h0001};
        vecs[4] = '{16'h2000, 16'h7FFF, 1'b1, 16'h1FFF, 16'h2000};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h7FFF, 16'h7FFF};
        vecs[6] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFE, 16'h7FFE};
        vecs[7] = '{16'h8000, 16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF};
        vecs[8] = '{16'h0003, 16'h4000, 1'b1, 16'h0001, 16'h0002};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("init");

        // Vector table; the first entry also checks the busy window length.
        for (int i = 0; i < 9; i++) begin
            busy_cyc = 0;
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp_t, vecs[i].exp_r);
            drain();
            if (i == 0) chk("busy_cycles", busy_cyc, LAT);
        end

        // Back-to-back: second start lands in the done cycle of the first.
        d0 = n_done;
        do_op(16'h4000, 16'h4000, 1'b0, 16'h2000, 16'h2000);
        for (int n = 0; n < 40 && !done; n++) @(negedge clk);
        chk("b2b_first_done", int'(done), 1);
        a = 16'h2000; b = 16'h7FFF; sign_in = 1'b1; start = 1'b1;
        push_exp(16'h1FFF, 16'h2000, 1'b1);
        @(negedge clk);
        start = 1'b0;
        drain();
        chk("b2b_done_count", n_done - d0, 2);

        // Starts during busy must be dropped.
        d0 = n_done;
        do_op(16'h1000, 16'h2000, 1'b0, 16'h0400, 16'h0400);
        repeat (3) @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        drain();
        repeat (25) @(negedge clk);
        chk("ignore_done_count", n_done - d0, 1);

        // Reset mid-operation aborts without a done.
        d0 = n_done;
        do_op(16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFE, 16'h7FFE);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrst");
        repeat (25) @(negedge clk);
        chk("midrst_no_done", n_done - d0, 0);
        do_op(16'h4000, 16'h4000, 1'b1, 16'h2000, 16'h2000);
        drain();

        // Reset after some activity, held two cycles.
        do_op(16'($urandom), 16'($urandom), 1'b1, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst2");
        repeat (20) @(negedge clk);
        chk("rst2_no_done", int'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
